// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: round-robin front end that shares one sequential signed Booth
// multiplier among NREQ requesters, with an abort if the multiplier never reports done.
//
// state | meaning
// IDLE  | no transaction in flight; round-robin search, grant on a pending request
// ISSUE | operands latched; one-cycle mul_start
// WAIT  | waiting for mul_done; down-counter aborts at terminal count
// RESP  | product (or timeout error) held for the owner until its rsp_ready
module booth_mult_arbiter #(
   parameter int NREQ     = 2,
   parameter int W        = 4,
   parameter int MAX_WAIT = 31
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   rsp_valid,
   input  logic [NREQ-1:0]   rsp_ready,
   output logic [2*W-1:0]    rsp_prod,
   output logic              rsp_err,
   output logic              mul_start,
   output logic [W-1:0]      mul_a,
   output logic [W-1:0]      mul_b,
   input  logic              mul_done,
   input  logic [2*W-1:0]    mul_prod,
   output logic              busy
);

   localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int IW1 = IW + 1;
   localparam int CW  = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   owner;
   logic [IW-1:0]   owner_inc;
   logic [IW-1:0]   sel_idx;
   logic            sel_found;
   logic [IW1-1:0]  cand;
   logic [CW-1:0]   wait_cnt;
   logic            grant;
   logic            capture;
   logic            timeout;
   logic            rsp_hs;

   // Walk downward so the last hit written is the closest one at or after rr_ptr.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = {1'b0, rr_ptr} + IW1'(k);
         if (cand >= IW1'(NREQ)) begin
            cand = cand - IW1'(NREQ);
         end
         if (req_valid[cand[IW-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = cand[IW-1:0];
         end
      end
   end

   assign owner_inc = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      capture   = 1'b0;
      timeout   = 1'b0;
      rsp_hs    = 1'b0;
      mul_start = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (sel_found) begin
               grant     = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            mul_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            // A done arriving on the terminal-count cycle still wins over the abort.
            if (mul_done) begin
               capture   = 1'b1;
               state_nxt = RESP;
            end else if (wait_cnt == '0) begin
               timeout   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (rsp_ready[owner]) begin
               rsp_hs    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr    <= '0;
         owner     <= '0;
         req_ready <= '0;
         rsp_valid <= '0;
         rsp_prod  <= '0;
         rsp_err   <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
         wait_cnt  <= '0;
      end else begin
         req_ready <= '0;
         if (grant) begin
            req_ready[sel_idx] <= 1'b1;
            owner              <= sel_idx;
            mul_a              <= req_a[sel_idx*W +: W];
            mul_b              <= req_b[sel_idx*W +: W];
         end

         // WAIT lasts MAX_WAIT cycles: loaded with MAX_WAIT-1, aborts on the cycle it reads zero.
         if (state == ISSUE) begin
            wait_cnt <= CW'(MAX_WAIT - 1);
         end else if (state == WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
         end

         if (capture) begin
            rsp_prod         <= mul_prod;
            rsp_err          <= 1'b0;
            rsp_valid[owner] <= 1'b1;
         end else if (timeout) begin
            rsp_prod         <= '0;
            rsp_err          <= 1'b1;
            rsp_valid[owner] <= 1'b1;
         end

         if (rsp_hs) begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rr_ptr    <= owner_inc;
         end
      end
   end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter with a behavioural multiplier that answers
// LAT cycles after start, or never when mdl_en is cleared.
module tb_booth_mult_arbiter;
   localparam int NREQ     = 2;
   localparam int W        = 4;
   localparam int MAX_WAIT = 31;
   localparam int LAT      = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   rsp_valid;
   logic [NREQ-1:0]   rsp_ready;
   logic [2*W-1:0]    rsp_prod;
   logic              rsp_err;
   logic              mul_start;
   logic [W-1:0]      mul_a;
   logic [W-1:0]      mul_b;
   logic              mul_done = 1'b0;
   logic [2*W-1:0]    mul_prod = '0;
   logic              busy;

   int n_checks  = 0;
   int n_errors  = 0;
   int start_cnt = 0;
   int grants[$];

   bit                mdl_en  = 1'b1;
   int                mdl_cnt = 0;
   logic signed [7:0] mdl_a   = '0;
   logic signed [7:0] mdl_b   = '0;

   always #5 clk = ~clk;

   booth_mult_arbiter #(.NREQ(NREQ), .W(W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_prod  (rsp_prod),
      .rsp_err   (rsp_err),
      .mul_start (mul_start),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_done  (mul_done),
      .mul_prod  (mul_prod),
      .busy      (busy)
   );

   // Multiplier model and monitors run on the falling edge, away from the DUT's edge.
   always @(negedge clk) begin
      mul_done = 1'b0;
      if (mdl_cnt != 0) begin
         mdl_cnt--;
         if (mdl_cnt == 0) begin
            mul_done = 1'b1;
            mul_prod = mdl_a * mdl_b;
         end
      end
      if (mul_start && mdl_en) begin
         mdl_cnt = LAT;
         mdl_a   = $signed(mul_a);
         mdl_b   = $signed(mul_b);
      end
      if (mul_start) start_cnt++;
      for (int i = 0; i < NREQ; i++) begin
         if (req_ready[i]) grants.push_back(i);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic post_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[idx*W +: W] = a;
      req_b[idx*W +: W] = b;
      req_valid[idx]    = 1'b1;
   endtask

   task automatic wait_grant(input int budget, output bit to);
      to = 1'b1;
      for (int n = 0; n < budget; n++) begin
         tick();
         if (req_ready != '0) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic wait_rsp(input int budget, output bit to);
      to = 1'b1;
      for (int n = 0; n < budget; n++) begin
         if (rsp_valid != '0) begin
            to = 1'b0;
            break;
         end
         tick();
      end
   endtask

   task automatic handshake(input int idx);
      rsp_ready[idx] = 1'b1;
      tick();
      rsp_ready[idx] = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) tick();
      n_checks++;
      if ({busy, mul_start, req_ready, rsp_valid, rsp_err, rsp_prod, mul_a, mul_b} !== 23'h0) begin
         n_errors++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {busy, mul_start, req_ready, rsp_valid, rsp_err, rsp_prod, mul_a, mul_b});
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (busy !== 1'b0 || req_ready !== 2'b00) begin
         n_errors++;
         $display("FAIL reset_idle: busy=%b req_ready=%b expected 0/00", busy, req_ready);
      end
   endtask

   task automatic test_single;
      bit to;
      int s0;
      s0 = start_cnt;
      post_req(0, 4'h3, 4'h5);
      wait_grant(10, to);
      n_checks++;
      if (to || req_ready !== 2'b01) begin
         n_errors++;
         $display("FAIL single_grant: got %b expected 01 (timeout=%0d)", req_ready, to);
      end
      req_valid[0] = 1'b0;
      tick();
      n_checks++;
      if (req_ready !== 2'b00) begin
         n_errors++;
         $display("FAIL single_ready_pulse: got %b expected 00", req_ready);
      end
      wait_rsp(50, to);
      n_checks++;
      if (to || rsp_valid !== 2'b01) begin
         n_errors++;
         $display("FAIL single_rsp_valid: got %b expected 01 (timeout=%0d)", rsp_valid, to);
      end
      n_checks++;
      if (rsp_prod !== 8'h0F || rsp_err !== 1'b0) begin
         n_errors++;
         $display("FAIL single_prod: got %h err=%b expected 0f err=0", rsp_prod, rsp_err);
      end
      n_checks++;
      if (start_cnt - s0 !== 1) begin
         n_errors++;
         $display("FAIL single_starts: got %0d expected 1", start_cnt - s0);
      end
      handshake(0);
      n_checks++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL single_release: rsp_valid=%b busy=%b expected 00/0", rsp_valid, busy);
      end
   endtask

   task automatic test_signed;
      bit to;
      post_req(1, 4'hD, 4'h5);
      wait_grant(10, to);
      n_checks++;
      if (to || req_ready !== 2'b10) begin
         n_errors++;
         $display("FAIL signed_grant: got %b expected 10", req_ready);
      end
      req_valid[1] = 1'b0;
      wait_rsp(50, to);
      n_checks++;
      if (to || rsp_valid !== 2'b10 || rsp_prod !== 8'hF1) begin
         n_errors++;
         $display("FAIL signed_neg: got valid=%b prod=%h expected 10/f1", rsp_valid, rsp_prod);
      end
      handshake(1);
      post_req(1, 4'h8, 4'h8);
      wait_grant(10, to);
      req_valid[1] = 1'b0;
      wait_rsp(50, to);
      n_checks++;
      if (to || rsp_valid !== 2'b10 || rsp_prod !== 8'h40 || rsp_err !== 1'b0) begin
         n_errors++;
         $display("FAIL signed_min: got valid=%b prod=%h err=%b expected 10/40/0",
                  rsp_valid, rsp_prod, rsp_err);
      end
      handshake(1);
   endtask

   task automatic test_contention;
      logic [NREQ-1:0] got_v[4];
      logic [7:0]      got_p[4];
      logic [NREQ-1:0] exp_v[4];
      logic [7:0]      exp_p[4];
      int nr;
      int g;
      exp_v = '{2'b01, 2'b10, 2'b01, 2'b10};
      exp_p = '{8'h06, 8'hF2, 8'h06, 8'hF2};
      got_v = '{default: '0};
      got_p = '{default: '0};
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      grants.delete();
      nr = 0;
      post_req(0, 4'h2, 4'h3);
      post_req(1, 4'hE, 4'h7);
      rsp_ready = 2'b11;
      for (int n = 0; n < 200 && nr < 4; n++) begin
         tick();
         if (rsp_valid != '0) begin
            got_v[nr] = rsp_valid;
            got_p[nr] = rsp_prod;
            nr++;
         end
      end
      req_valid = '0;
      tick();
      rsp_ready = '0;
      n_checks++;
      if (nr !== 4 || grants.size() !== 4) begin
         n_errors++;
         $display("FAIL contention_count: responses=%0d grants=%0d expected 4/4", nr, grants.size());
      end
      for (int i = 0; i < 4; i++) begin
         g = (i < grants.size()) ? grants[i] : -1;
         n_checks++;
         if (g !== i % 2) begin
            n_errors++;
            $display("FAIL contention_grant%0d: got %0d expected %0d", i, g, i % 2);
         end
         n_checks++;
         if (got_v[i] !== exp_v[i] || got_p[i] !== exp_p[i]) begin
            n_errors++;
            $display("FAIL contention_rsp%0d: got valid=%b prod=%h expected %b/%h",
                     i, got_v[i], got_p[i], exp_v[i], exp_p[i]);
         end
      end
   endtask

   task automatic test_backpressure;
      bit to;
      bit stable;
      int s0;
      post_req(0, 4'h7, 4'hF);
      wait_grant(10, to);
      req_valid[0] = 1'b0;
      wait_rsp(50, to);
      s0 = start_cnt;
      post_req(1, 4'h1, 4'h1);
      rsp_ready = 2'b10;
      stable = 1'b1;
      for (int n = 0; n < 10; n++) begin
         tick();
         if (rsp_valid !== 2'b01 || rsp_prod !== 8'hF9 || rsp_err !== 1'b0) stable = 1'b0;
      end
      n_checks++;
      if (to || stable !== 1'b1) begin
         n_errors++;
         $display("FAIL bp_hold: got valid=%b prod=%h stable=%0d expected 01/f9/1",
                  rsp_valid, rsp_prod, stable);
      end
      n_checks++;
      if (start_cnt !== s0) begin
         n_errors++;
         $display("FAIL bp_no_start: got %0d starts expected 0", start_cnt - s0);
      end
      rsp_ready = 2'b01;
      tick();
      rsp_ready = 2'b00;
      n_checks++;
      if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
         n_errors++;
         $display("FAIL bp_release: valid=%b ready=%b expected 00/00", rsp_valid, req_ready);
      end
      tick();
      n_checks++;
      if (req_ready !== 2'b10) begin
         n_errors++;
         $display("FAIL bp_next_grant: got %b expected 10", req_ready);
      end
      req_valid[1] = 1'b0;
      wait_rsp(50, to);
      n_checks++;
      if (to || rsp_valid !== 2'b10 || rsp_prod !== 8'h01) begin
         n_errors++;
         $display("FAIL bp_second: got valid=%b prod=%h expected 10/01", rsp_valid, rsp_prod);
      end
      handshake(1);
   endtask

   task automatic test_timeout;
      bit to;
      int n;
      mdl_en = 1'b0;
      post_req(0, 4'h3, 4'h3);
      wait_grant(10, to);
      req_valid[0] = 1'b0;
      n_checks++;
      if (to || mul_start !== 1'b1) begin
         n_errors++;
         $display("FAIL to_start: got %b expected 1", mul_start);
      end
      // Start cycle, then MAX_WAIT wait cycles, then the response appears.
      n = 0;
      for (int k = 0; k < 60; k++) begin
         tick();
         n++;
         if (rsp_valid != '0) break;
      end
      n_checks++;
      if (n !== MAX_WAIT + 1) begin
         n_errors++;
         $display("FAIL to_latency: got %0d cycles expected %0d", n, MAX_WAIT + 1);
      end
      n_checks++;
      if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_prod !== 8'h00) begin
         n_errors++;
         $display("FAIL to_rsp: got valid=%b err=%b prod=%h expected 01/1/00",
                  rsp_valid, rsp_err, rsp_prod);
      end
      handshake(0);
      n_checks++;
      if (rsp_err !== 1'b0 || rsp_valid !== 2'b00) begin
         n_errors++;
         $display("FAIL to_clear: got err=%b valid=%b expected 0/00", rsp_err, rsp_valid);
      end
      mdl_en = 1'b1;
   endtask

   task automatic test_reset_in_wait;
      bit to;
      bit quiet;
      int s0;
      post_req(0, 4'h2, 4'h2);
      wait_grant(10, to);
      req_valid[0] = 1'b0;
      tick();
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({busy, mul_start, req_ready, rsp_valid, rsp_err, rsp_prod, mul_a, mul_b} !== 23'h0) begin
         n_errors++;
         $display("FAIL rst_wait_outputs: got %h expected 0",
                  {busy, mul_start, req_ready, rsp_valid, rsp_err, rsp_prod, mul_a, mul_b});
      end
      tick();
      rst = 1'b0;
      s0 = start_cnt;
      quiet = 1'b1;
      for (int n = 0; n < 6; n++) begin
         tick();
         if (busy !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b00) quiet = 1'b0;
      end
      n_checks++;
      if (quiet !== 1'b1 || start_cnt !== s0) begin
         n_errors++;
         $display("FAIL rst_late_done: quiet=%0d starts=%0d expected 1/0", quiet, start_cnt - s0);
      end
      post_req(1, 4'hD, 4'hD);
      wait_grant(10, to);
      n_checks++;
      if (to || req_ready !== 2'b10) begin
         n_errors++;
         $display("FAIL rst_next_grant: got %b expected 10", req_ready);
      end
      req_valid[1] = 1'b0;
      wait_rsp(50, to);
      n_checks++;
      if (to || rsp_valid !== 2'b10 || rsp_prod !== 8'h09 || rsp_err !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_next_rsp: got valid=%b prod=%h err=%b expected 10/09/0",
                  rsp_valid, rsp_prod, rsp_err);
      end
      handshake(1);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = '0;
      test_reset();
      test_single();
      test_signed();
      test_contention();
      test_backpressure();
      test_timeout();
      test_reset_in_wait();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
